// File: rtl/button_conditioner.sv
// Five-button 2-flop sync + debounce; level/press/release appear DEBOUNCE_CYCLES+2 clocks after the first sampling edge,
// mode/step one clock later; no backpressure. `define BUTTON_AUTO_REPEAT_EN adds hold-to-repeat step pulses for up/down.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release,
    output logic [1:0] mode,
    output logic       step_faster,
    output logic       step_slower
);

    localparam int NB = 5;

    localparam logic [1:0] S_LOW   = 2'd0;
    localparam logic [1:0] S_CHK_H = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_CHK_L = 2'd3;

    localparam logic [1:0] MODE_LEFT  = 2'd0;
    localparam logic [1:0] MODE_RIGHT = 2'd1;
    localparam logic [1:0] MODE_STOP  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_dc
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if ((longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYCLES)) begin : g_chk_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end

    logic [NB-1:0]    sync1_q;
    logic [NB-1:0]    sync2_q;
    logic [1:0]       st_q   [NB];
    logic [1:0]       st_d   [NB];
    logic [CNT_W-1:0] cnt_q  [NB];
    logic [CNT_W-1:0] cnt_d  [NB];
    logic [NB-1:0]    deb;
    logic [NB-1:0]    level_q;
    logic [NB-1:0]    level_d;
    logic [NB-1:0]    press_q;
    logic [NB-1:0]    press_d;
    logic [NB-1:0]    release_q;
    logic [NB-1:0]    release_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic             faster_q;
    logic             faster_d;
    logic             slower_q;
    logic             slower_d;
    logic             rep_up;
    logic             rep_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // A single opposite sample during a check aborts it, so the counter only ever climbs to CNT_LAST.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = '0;
            case (st_q[i])
                S_LOW: begin
                    if (sync2_q[i]) begin
                        st_d[i]  = S_CHK_H;
                        cnt_d[i] = CNT_W'(1);
                    end
                end
                S_CHK_H: begin
                    if (!sync2_q[i]) begin
                        st_d[i] = S_LOW;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        st_d[i] = S_HIGH;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!sync2_q[i]) begin
                        st_d[i]  = S_CHK_L;
                        cnt_d[i] = CNT_W'(1);
                    end
                end
                default: begin
                    if (sync2_q[i]) begin
                        st_d[i] = S_HIGH;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        st_d[i] = S_LOW;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                st_q[i]  <= S_LOW;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        deb = '0;
        for (int i = 0; i < NB; i++) begin
            deb[i] = (st_q[i] == S_HIGH) || (st_q[i] == S_CHK_L);
        end
    end

    // Level and edge pulses come from the same register stage so they change together.
    always_comb begin
        level_d   = deb;
        press_d   = deb & ~level_q;
        release_d = ~deb & level_q;
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W  = $clog2(REP_MAX + 1);

    logic [HOLD_W-1:0] hold_q [2];
    logic [HOLD_W-1:0] hold_d [2];
    logic [1:0]        rep_ph_q;
    logic [1:0]        rep_ph_d;
    logic [1:0]        rep_fire;
    logic [1:0]        held;

    assign held = {level_q[4], level_q[0]};

    // hold_q counts cycles since the press; after the first repeat it restarts and counts the period.
    always_comb begin
        rep_fire = '0;
        rep_ph_d = rep_ph_q;
        for (int d = 0; d < 2; d++) begin
            hold_d[d]   = hold_q[d] + HOLD_W'(1);
            rep_fire[d] = rep_ph_q[d] ? (hold_q[d] == HOLD_W'(REPEAT_PERIOD))
                                      : (hold_q[d] == HOLD_W'(REPEAT_DELAY));
            if (!held[d]) begin
                hold_d[d]   = '0;
                rep_ph_d[d] = 1'b0;
            end else if (rep_fire[d]) begin
                hold_d[d]   = HOLD_W'(1);
                rep_ph_d[d] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q[0] <= '0;
            hold_q[1] <= '0;
            rep_ph_q  <= '0;
        end else begin
            hold_q[0] <= hold_d[0];
            hold_q[1] <= hold_d[1];
            rep_ph_q  <= rep_ph_d;
        end
    end

    assign rep_up = rep_fire[0] & held[0] & ~held[1];
    assign rep_dn = rep_fire[1] & held[1] & ~held[0];
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    always_comb begin
        mode_d = mode_q;
        if (press_q[1]) begin
            mode_d = MODE_LEFT;
        end else if (press_q[3]) begin
            mode_d = MODE_RIGHT;
        end else if (press_q[2]) begin
            mode_d = MODE_STOP;
        end
        faster_d = (press_q[0] & ~press_q[4]) | rep_up;
        slower_d = (press_q[4] & ~press_q[0]) | rep_dn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            mode_q    <= MODE_STOP;
            faster_q  <= 1'b0;
            slower_q  <= 1'b0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            mode_q    <= mode_d;
            faster_q  <= faster_d;
            slower_q  <= slower_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign mode        = mode_q;
    assign step_faster = faster_q;
    assign step_slower = slower_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: per-cycle comparison against a sample-history model, a vector table,
// hand-written timing sequences and randomized bouncing inputs.
module tb_button_conditioner;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_raw = 5'b0;
    logic [4:0] btn_level, btn_press, btn_release;
    logic [1:0] mode;
    logic       step_faster, step_slower;

    int checks = 0;
    int failures = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(4),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .mode(mode),
        .step_faster(step_faster),
        .step_slower(step_slower)
    );

    always #5 clk = ~clk;

    // Reference: accepted value flips once the last DC synchronised samples all disagree with it.
    logic [4:0] rawq[$];
    logic [4:0] syncq[$];
    logic [4:0] m_acc, m_level, m_press, m_release;
    logic [1:0] m_mode;
    logic       m_sf, m_ss;
`ifdef BUTTON_AUTO_REPEAT_EN
    int age_u, age_d;

    function automatic bit rep_due(input int age);
        return (age >= RD) && (((age - RD) % RP) == 0);
    endfunction
`endif

    task automatic model_reset();
        rawq.delete();
        syncq.delete();
        m_acc = '0; m_level = '0; m_press = '0; m_release = '0;
        m_mode = 2'd2; m_sf = 1'b0; m_ss = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
        age_u = 0; age_d = 0;
`endif
    endtask

    task automatic model_edge(input logic [4:0] raw);
        logic [4:0] old_press, old_lvl, s;
        bit flip;
        old_press = m_press;
        old_lvl   = m_level;
        m_sf = old_press[0] & ~old_press[4];
        m_ss = old_press[4] & ~old_press[0];
`ifdef BUTTON_AUTO_REPEAT_EN
        if (old_lvl[0] && !old_lvl[4] && rep_due(age_u)) m_sf = 1'b1;
        if (old_lvl[4] && !old_lvl[0] && rep_due(age_d)) m_ss = 1'b1;
        age_u = old_lvl[0] ? age_u + 1 : 0;
        age_d = old_lvl[4] ? age_d + 1 : 0;
`endif
        if (old_press[1])      m_mode = 2'd0;
        else if (old_press[3]) m_mode = 2'd1;
        else if (old_press[2]) m_mode = 2'd2;
        m_press   = m_acc & ~old_lvl;
        m_release = ~m_acc & old_lvl;
        m_level   = m_acc;
        rawq.push_back(raw);
        s = (rawq.size() >= 3) ? rawq[rawq.size() - 3] : 5'b0;
        syncq.push_back(s);
        if (syncq.size() >= DC) begin
            for (int b = 0; b < 5; b++) begin
                flip = 1'b1;
                for (int k = 1; k <= DC; k++)
                    if (syncq[syncq.size() - k][b] == m_acc[b]) flip = 1'b0;
                if (flip) m_acc[b] = ~m_acc[b];
            end
        end
        if (rawq.size() > 8)  void'(rawq.pop_front());
        if (syncq.size() > 8) void'(syncq.pop_front());
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("level", 32'(btn_level), 32'(m_level));
        check("press", 32'(btn_press), 32'(m_press));
        check("release", 32'(btn_release), 32'(m_release));
        check("mode", 32'(mode), 32'(m_mode));
        check("step_faster", 32'(step_faster), 32'(m_sf));
        check("step_slower", 32'(step_slower), 32'(m_ss));
    endtask

    task automatic tick(input logic [4:0] raw);
        @(negedge clk);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        check_all();
    endtask

    // Called just after a tick; reset is asserted and released between clock edges.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("async_reset_mode", 32'(mode), 32'd2);
        #1 rst_n = 1'b1;
    endtask

    // kind 0: press[b], 1: release[b], 2: step_faster. n = ticks until seen, -1 on timeout.
    task automatic wait_ev(input int kind, input int b, input logic [4:0] raw, input int max, output int n);
        n = -1;
        for (int k = 1; k <= max && n < 0; k++) begin
            tick(raw);
            case (kind)
                0:       if (btn_press[b])   n = k;
                1:       if (btn_release[b]) n = k;
                default: if (step_faster)    n = k;
            endcase
        end
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) tick(5'b0);
    endtask

    typedef struct {
        logic [4:0] raw;
        logic [4:0] exp_level;
        logic [1:0] exp_mode;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int n, n2, steps;
        logic [4:0] seen, raw;
        int offs[$];
        int exp_offs[$];

        vecs[0] = '{5'b00010, 5'b00010, 2'd0};
        vecs[1] = '{5'b01000, 5'b01000, 2'd1};
        vecs[2] = '{5'b00100, 5'b00100, 2'd2};
        vecs[3] = '{5'b01110, 5'b01110, 2'd0};
        vecs[4] = '{5'b01100, 5'b01100, 2'd1};
        vecs[5] = '{5'b00001, 5'b00001, 2'd2};
        vecs[6] = '{5'b11111, 5'b11111, 2'd0};
        vecs[7] = '{5'b10100, 5'b10100, 2'd2};

        // Reset with every button held.
        model_reset();
        btn_raw = 5'b11111;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_mode", 32'(mode), 32'd2);
        #2 rst_n = 1'b1;

        // Left held from reset release: accepted 6 clocks after the first sampling edge.
        tick(5'b00010);
        wait_ev(0, 1, 5'b00010, 20, n);
        check("left_press_latency", 32'(n), 32'd6);
        check("left_level", 32'(btn_level[1]), 32'd1);
        tick(5'b00010);
        check("left_press_one_cycle", 32'(btn_press[1]), 32'd0);
        check("left_mode", 32'(mode), 32'd0);

        // Bounce on right, then a clean hold and release.
        idle(10);
        seen = '0;
        tick(5'b01000); seen |= btn_press;
        tick(5'b00000); seen |= btn_press;
        tick(5'b01000); seen |= btn_press;
        tick(5'b01000); seen |= btn_press;
        tick(5'b00000); seen |= btn_press;
        tick(5'b01000); seen |= btn_press;
        check("bounce_no_press", 32'(seen), 32'd0);
        wait_ev(0, 3, 5'b01000, 20, n);
        check("bounce_press_latency", 32'(n), 32'd6);
        tick(5'b01000);
        check("bounce_mode", 32'(mode), 32'd1);
        tick(5'b01000);
        tick(5'b00000);
        wait_ev(1, 3, 5'b00000, 20, n);
        check("release_latency", 32'(n), 32'd6);
        tick(5'b00000);
        check("release_one_cycle", 32'(btn_release[3]), 32'd0);

        // Priority: left, centre and right together.
        idle(8);
        tick(5'b01110);
        wait_ev(0, 1, 5'b01110, 20, n);
        check("prio_press_latency", 32'(n), 32'd6);
        check("prio_three_presses", 32'(btn_press), 32'b01110);
        tick(5'b01110);
        check("prio_mode_left", 32'(mode), 32'd0);
        idle(10);
        for (int k = 0; k < 10; k++) tick(5'b00100);
        check("centre_mode_stop", 32'(mode), 32'd2);

        // Speed steps.
        idle(10);
        tick(5'b00001);
        wait_ev(0, 0, 5'b00001, 20, n);
        check("up_press_latency", 32'(n), 32'd6);
        wait_ev(2, 0, 5'b00001, 3, n2);
        check("step_faster_delay", 32'(n2), 32'd1);
        idle(10);
        seen = '0;
        steps = 0;
        for (int k = 0; k < 14; k++) begin
            tick(5'b10001);
            seen |= btn_press;
            if (step_faster || step_slower) steps++;
        end
        check("updown_presses", 32'(seen), 32'b10001);
        check("updown_no_step", 32'(steps), 32'd0);

        // Hold up: repeat pulses only when the optional feature is built in.
        idle(10);
        tick(5'b00001);
        wait_ev(0, 0, 5'b00001, 20, n);
        check("hold_press_latency", 32'(n), 32'd6);
        for (int k = 1; k <= 25; k++) begin
            tick(5'b00001);
            if (step_faster) offs.push_back(k);
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        exp_offs = '{1, 11, 14, 17, 20, 23};
`else
        exp_offs = '{1};
`endif
        check("hold_step_count", 32'(offs.size()), 32'(exp_offs.size()));
        for (int i = 0; i < exp_offs.size() && i < offs.size(); i++)
            check("hold_step_offset", 32'(offs[i]), 32'(exp_offs[i]));

        // Reset two clocks into the high check.
        idle(10);
        tick(5'b00010);
        tick(5'b00010);
        tick(5'b00010);
        tick(5'b00010);
        tick(5'b00010);
        check("midcheck_no_level", 32'(btn_level[1]), 32'd0);
        reset_pulse();
        check("midcheck_reset_level", 32'(btn_level), 32'd0);
        tick(5'b00010);
        wait_ev(0, 1, 5'b00010, 20, n);
        check("midcheck_reaccept", 32'(n), 32'd6);

        // Vector table: from reset, hold a pattern and check settled level and mode.
        for (int v = 0; v < 8; v++) begin
            reset_pulse();
            for (int k = 0; k < 10; k++) tick(vecs[v].raw);
            check("vec_level", 32'(btn_level), 32'(vecs[v].exp_level));
            check("vec_mode", 32'(mode), 32'(vecs[v].exp_mode));
        end

        // Randomized bouncing and holds, with occasional resets.
        reset_pulse();
        raw = '0;
        for (int seg = 0; seg < 300; seg++) begin
            raw = raw ^ 5'($urandom_range(0, 31) & $urandom_range(0, 31));
            n = $urandom_range(1, 9);
            for (int k = 0; k < n; k++) tick(raw);
            if ($urandom_range(0, 49) == 0) reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
